// File: rtl/bit_stuffer_param.sv
// Bit-stuffing stage: inserts STUFF_VAL after RUN_LEN consecutive MATCH_VAL bits.
// Optional stuffed-bit statistics counter enabled by BIT_STUFFER_STATS_EN.
module bit_stuffer_param #(
    parameter int   RUN_LEN   = 6,
    parameter logic MATCH_VAL = 1'b1,
    parameter logic STUFF_VAL = 1'b0,
    parameter int   CNT_W     = $clog2(RUN_LEN + 1)
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        in_bit,
    input  logic        in_valid,
    input  logic        in_bypass,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_bit,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready
`ifdef BIT_STUFFER_STATS_EN
    ,
    output logic [15:0] stuff_cnt
`endif
);

    localparam logic [0:0]       PASS    = 1'b0;
    localparam logic [0:0]       STUFF   = 1'b1;
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

    logic [0:0]       state;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_nxt;
    logic             pend_last;
    logic             free;
    logic             accept;
    logic             hit;
    logic             stuff_load;

    always_comb begin
        free       = !out_valid || out_ready;
        in_ready   = (state == PASS) && free;
        accept     = in_valid && in_ready;
        stuff_load = (state == STUFF) && free;
        run_nxt    = '0;
        if (!in_bypass && (in_bit == MATCH_VAL))
            run_nxt = run_cnt + CNT_W'(1);
        hit = !in_bypass && (run_nxt == RUN_MAX);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= PASS;
            run_cnt   <= '0;
            pend_last <= 1'b0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_bit   <= in_bit;
            out_valid <= 1'b1;
            if (hit) begin
                // last flag moves onto the trailing stuff bit
                run_cnt   <= '0;
                state     <= STUFF;
                pend_last <= in_last;
                out_last  <= 1'b0;
            end else begin
                run_cnt  <= in_last ? '0 : run_nxt;
                out_last <= in_last;
            end
        end else if (stuff_load) begin
            out_bit   <= STUFF_VAL;
            out_valid <= 1'b1;
            out_last  <= pend_last;
            pend_last <= 1'b0;
            state     <= PASS;
        end else if (free) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BIT_STUFFER_STATS_EN
    always_ff @(posedge clk) begin
        if (RST)
            stuff_cnt <= '0;
        else if (stuff_load && (stuff_cnt != 16'hFFFF))
            stuff_cnt <= stuff_cnt + 16'd1;
    end
`endif

endmodule
